// File: rtl/imm_extend_pipe.sv
// Pipelined immediate-extension stage (zero/sign/upper/branch-offset) with valid/ready handshake.
// Define IMM_SKID_EN to add a one-entry skid register and a registered in_ready.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
);

  typedef enum logic [2:0] {
    MODE_ZERO   = 3'd0,
    MODE_SIGN   = 3'd1,
    MODE_UPPER  = 3'd2,
    MODE_BRANCH = 3'd3
  } mode_e;

  logic [OUT_W-1:0] ext_data;
  logic             ext_err;
  logic [OUT_W-1:0] sext;

  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q,  out_data_d;
  logic             out_err_q,   out_err_d;

  logic             in_fire;
  logic             out_fire;

  assign sext = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};

  always_comb begin
    ext_data = '0;
    ext_err  = 1'b0;
    case (in_mode)
      MODE_ZERO:   ext_data = {{(OUT_W-IN_W){1'b0}}, in_imm};
      MODE_SIGN:   ext_data = sext;
      MODE_UPPER:  ext_data = {in_imm, {(OUT_W-IN_W){1'b0}}};
      MODE_BRANCH: ext_data = {sext[OUT_W-3:0], 2'b00};
      default:     ext_err  = 1'b1;
    endcase
  end

  assign out_fire  = out_valid_q && out_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

`ifdef IMM_SKID_EN
  logic             skid_valid_q, skid_valid_d;
  logic [OUT_W-1:0] skid_data_q,  skid_data_d;
  logic             skid_err_q,   skid_err_d;
  logic             in_ready_q,   in_ready_d;

  assign in_ready = in_ready_q;

  // The skid slot can only be occupied while the output register is valid,
  // and in_ready is low while it is occupied, so a skid drain never races an input.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_err_d    = out_err_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_err_d   = skid_err_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_fire) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_err_d    = skid_err_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_valid_d = 1'b1;
        out_data_d  = ext_data;
        out_err_d   = ext_err;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = ext_data;
      skid_err_d   = ext_err;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_err_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_err_q   <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_err_q    <= out_err_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_err_q   <= skid_err_d;
      in_ready_q   <= in_ready_d;
    end
  end
`else
  assign in_ready = !out_valid_q || out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (in_fire) begin
      out_valid_d = 1'b1;
      out_data_d  = ext_data;
      out_err_d   = ext_err;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed self-checking bench for imm_extend_pipe (default and IMM_SKID_EN builds).
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [2:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;

  logic        s_flush;
  logic        s_in_valid;
  logic        s_in_ready;
  logic [11:0] s_in_imm;
  logic [2:0]  s_in_mode;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [15:0] s_out_data;
  logic        s_out_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_mode [4] = '{32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004};
  logic [15:0] exp_sw   [4] = '{16'h0FFF, 16'hFFFF, 16'hFFF0, 16'hFFFC};

  localparam logic [31:0] A_EXP = 32'h00001234;
  localparam logic [31:0] B_EXP = 32'h00000F0F;
  localparam logic [31:0] C_EXP = 32'h00007777;

  always #5 clk = ~clk;

  imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  imm_extend_pipe #(.IN_W(12), .OUT_W(16)) dut_s (
    .clk(clk), .rst(rst), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_imm(s_in_imm), .in_mode(s_in_mode),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_err(s_out_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #12 rst = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 00000000", out_data); end
    n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", out_err); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_modes;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_imm = 16'h8001; in_mode = 3'(i); out_ready = 1'b1;
      tick;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mode%0d_valid: got %b expected 1", i, out_valid); end
      n_checks++; if (out_data !== exp_mode[i]) begin n_fail++; $display("FAIL mode%0d_data: got %h expected %h", i, out_data, exp_mode[i]); end
      n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL mode%0d_err: got %b expected 0", i, out_err); end
    end
    in_valid = 1'b0;
    tick;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_data !== 32'hFFFE0004) begin n_fail++; $display("FAIL hold_data: got %h expected fffe0004", out_data); end
  endtask

  task automatic test_reserved;
    in_valid = 1'b1; in_imm = 16'hABCD; in_mode = 3'd5; out_ready = 1'b1;
    tick;
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL rsv_data: got %h expected 00000000", out_data); end
    n_checks++; if (out_err !== 1'b1) begin n_fail++; $display("FAIL rsv_err: got %b expected 1", out_err); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rsv_valid: got %b expected 1", out_valid); end
    in_imm = 16'h0001; in_mode = 3'd1;
    tick;
    n_checks++; if (out_data !== 32'h00000001) begin n_fail++; $display("FAIL post_rsv_data: got %h expected 00000001", out_data); end
    n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL post_rsv_err: got %b expected 0", out_err); end
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 3'd0; in_imm = 16'h1234;
    tick;
    n_checks++; if (out_data !== A_EXP) begin n_fail++; $display("FAIL bp_a_data: got %h expected %h", out_data, A_EXP); end
`ifdef IMM_SKID_EN
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_a: got %b expected 1", in_ready); end
    in_imm = 16'h0F0F;
    tick;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b expected 0", in_ready); end
    in_imm = 16'h7777;
    tick;
    n_checks++; if (out_data !== A_EXP) begin n_fail++; $display("FAIL bp_a_held: got %h expected %h", out_data, A_EXP); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_held: got %b expected 0", in_ready); end
    out_ready = 1'b1;
    tick;
    n_checks++; if (out_data !== B_EXP) begin n_fail++; $display("FAIL bp_b_data: got %h expected %h", out_data, B_EXP); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_drain: got %b expected 1", in_ready); end
    tick;
`else
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_a: got %b expected 0", in_ready); end
    in_imm = 16'h0F0F;
    tick;
    n_checks++; if (out_data !== A_EXP) begin n_fail++; $display("FAIL bp_a_held: got %h expected %h", out_data, A_EXP); end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_comb: got %b expected 1", in_ready); end
    tick;
    n_checks++; if (out_data !== B_EXP) begin n_fail++; $display("FAIL bp_b_data: got %h expected %h", out_data, B_EXP); end
    in_imm = 16'h7777;
    tick;
`endif
    n_checks++; if (out_data !== C_EXP) begin n_fail++; $display("FAIL bp_c_data: got %h expected %h", out_data, C_EXP); end
    in_valid = 1'b0;
    tick;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got %b expected 0", out_valid); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 3'd0; in_imm = 16'h1234;
    tick;
    in_imm = 16'h0F0F;
    tick;
    flush = 1'b1; in_imm = 16'hDEAD;
    tick;
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
    // Input accepted in the flush cycle must be discarded.
    in_valid = 1'b1; flush = 1'b1; in_imm = 16'hBEEF;
    tick;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_data !== A_EXP) begin n_fail++; $display("FAIL flush_keep_data: got %h expected %h", out_data, A_EXP); end
    tick;
    tick;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_never_out: got %b expected 0", out_valid); end
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 3'd1; in_imm = 16'h4321;
    tick;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ar_pre_valid: got %b expected 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b expected 0", out_valid); end
    #1 rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ar_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL ar_data: got %h expected 00000000", out_data); end
    tick;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_post_valid: got %b expected 0", out_valid); end
    out_ready = 1'b1;
  endtask

  task automatic test_param_sweep;
    for (int i = 0; i < 4; i++) begin
      s_in_valid = 1'b1; s_in_imm = 12'hFFF; s_in_mode = 3'(i);
      tick;
      n_checks++; if (s_out_valid !== 1'b1) begin n_fail++; $display("FAIL sw_mode%0d_valid: got %b expected 1", i, s_out_valid); end
      n_checks++; if (s_out_data !== exp_sw[i]) begin n_fail++; $display("FAIL sw_mode%0d_data: got %h expected %h", i, s_out_data, exp_sw[i]); end
    end
    s_in_valid = 1'b0;
    tick;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_imm = '0; in_mode = '0; out_ready = 1'b1;
    s_flush = 1'b0; s_in_valid = 1'b0; s_in_imm = '0; s_in_mode = '0; s_out_ready = 1'b1;
    test_reset;
    test_modes;
    test_reserved;
    test_back_to_back;
    test_flush;
    test_async_reset;
    test_param_sweep;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
